// File: rtl/audio_pkg.sv
// Shared audio types: sample word and the output-stage state encoding.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    OUT_EMPTY,
    OUT_FETCH,
    OUT_VALID
  } out_state_t;

endpackage

// File: rtl/sample_dpram.sv
// Simple dual-port RAM: one write port, one read port with enable and a
// 1-cycle registered read. Written to infer a block RAM (no reset on the array
// or on the read register).
module sample_dpram
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = SAMPLE_W,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; data appears the cycle after rd_en_i.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_ring_buffer.sv
// Sample ring buffer: strobe-written, ready/valid read ring buffer of PCM
// samples backed by an inferred block RAM, with fill level, threshold flag and
// overflow accounting.
// Optional feature: define SAMPLE_RING_BUFFER_PEAK_FILL_EN to track the
// high-water mark of the fill level on peak_fill_o (tied to 0 otherwise).
module sample_ring_buffer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W       = SAMPLE_W,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READY_THRESH = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic                   wr_valid_i,
  input  logic                   flush_i,
  output logic [DATA_W-1:0]      ram_read_data_o,
  output logic                   ram_read_valid_o,
  input  logic                   ram_read_ready_i,
  output logic                   ram_buffer_ready_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   overflow_o,
  output logic [15:0]            drop_count_o,
  output logic [$clog2(DEPTH):0] peak_fill_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sample_ring_buffer: DEPTH must be a power of two and >= 4");
  end
  if ((READY_THRESH < 1) || (READY_THRESH > DEPTH)) begin : g_bad_thresh
    $error("sample_ring_buffer: READY_THRESH must be in 1..DEPTH");
  end

  out_state_t        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]     fill_q, fill_d;
  logic [FW-1:0]     stage_cnt;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] ram_rd_data;
  logic              ram_rd_en;
  logic              load_out;
  logic              has_unfetched;
  logic              wr_accept;
  logic              wr_drop;
  logic              xfer;
  logic              is_full;
  logic              bufrdy_q;
  logic              overflow_q;
  logic [15:0]       drop_cnt_q;

  // Full check uses the registered fill, so a same-cycle transfer never frees
  // room for a write at full.
  assign is_full   = (fill_q == FW'(DEPTH));
  assign wr_accept = wr_valid_i && !flush_i && !is_full;
  assign wr_drop   = wr_valid_i && !flush_i && is_full;
  assign xfer      = (state_q == OUT_VALID) && ram_read_ready_i;

  // Entries held by the output stage (read in flight or output register).
  // Deriving "unfetched" from fill keeps a full buffer with equal pointers
  // unambiguous.
  assign stage_cnt     = (state_q == OUT_EMPTY) ? '0 : FW'(1);
  assign has_unfetched = (fill_q != stage_cnt);

  assign fill_d = fill_q + FW'(wr_accept) - FW'(xfer);

  sample_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  // Output FSM next state, RAM read enable and output-register load.
  always_comb begin
    state_d   = state_q;
    ram_rd_en = 1'b0;
    load_out  = 1'b0;
    unique case (state_q)
      OUT_EMPTY: begin
        if (has_unfetched) begin
          ram_rd_en = 1'b1;
          state_d   = OUT_FETCH;
        end
      end
      OUT_FETCH: begin
        load_out = 1'b1;
        state_d  = OUT_VALID;
      end
      OUT_VALID: begin
        if (ram_read_ready_i) begin
          if (has_unfetched) begin
            ram_rd_en = 1'b1;
            state_d   = OUT_FETCH;
          end else begin
            state_d = OUT_EMPTY;
          end
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
    if (flush_i) begin
      state_d   = OUT_EMPTY;
      ram_rd_en = 1'b0;
      load_out  = 1'b0;
    end
  end

  // FSM state, pointers and fill level; flush clears them like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q  <= OUT_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      if (wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (ram_rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Output register, loaded from the RAM read port in OUT_FETCH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data_q <= '0;
    end else if (load_out) begin
      out_data_q <= ram_rd_data;
    end
  end

  // Threshold flag, one cycle behind fill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bufrdy_q <= 1'b0;
    end else begin
      bufrdy_q <= (fill_q >= FW'(READY_THRESH));
    end
  end

  // Sticky overflow flag and saturating dropped-write counter.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (wr_drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

`ifdef SAMPLE_RING_BUFFER_PEAK_FILL_EN
  logic [FW-1:0] peak_q;

  // High-water mark of fill, one cycle behind fill.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      peak_q <= '0;
    end else if (fill_q > peak_q) begin
      peak_q <= fill_q;
    end
  end

  assign peak_fill_o = peak_q;
`else
  assign peak_fill_o = '0;
`endif

  assign ram_read_data_o    = out_data_q;
  assign ram_read_valid_o   = (state_q == OUT_VALID);
  assign ram_buffer_ready_o = bufrdy_q;
  assign fill_o             = fill_q;
  assign overflow_o         = overflow_q;
  assign drop_count_o       = drop_cnt_q;

endmodule

// File: tb/tb_sample_ring_buffer.sv
// Testbench for sample_ring_buffer at DEPTH=8, READY_THRESH=4 against a
// queue-based reference model of the buffer contents and status flags.
module tb_sample_ring_buffer;

  localparam int DW     = 24;
  localparam int DEPTH  = 8;
  localparam int THRESH = 4;
  localparam int FW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] wr_data_i = '0;
  logic          wr_valid_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [DW-1:0] ram_read_data_o;
  logic          ram_read_valid_o;
  logic          ram_read_ready_i = 1'b0;
  logic          ram_buffer_ready_o;
  logic [FW-1:0] fill_o;
  logic          overflow_o;
  logic [15:0]   drop_count_o;
  logic [FW-1:0] peak_fill_o;

  sample_ring_buffer #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .READY_THRESH (THRESH)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .wr_data_i          (wr_data_i),
    .wr_valid_i         (wr_valid_i),
    .flush_i            (flush_i),
    .ram_read_data_o    (ram_read_data_o),
    .ram_read_valid_o   (ram_read_valid_o),
    .ram_read_ready_i   (ram_read_ready_i),
    .ram_buffer_ready_o (ram_buffer_ready_o),
    .fill_o             (fill_o),
    .overflow_o         (overflow_o),
    .drop_count_o       (drop_count_o),
    .peak_fill_o        (peak_fill_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stored samples in order plus status flags.
  logic [DW-1:0] exp_q[$];
  bit            m_ovf = 1'b0;
  int            m_drops = 0;
  int            m_peak = 0;
  bit            m_bufrdy = 1'b0;
  int            n_xfer = 0;

  function automatic int exp_peak();
`ifdef SAMPLE_RING_BUFFER_PEAK_FILL_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  // One clock cycle: sample handshake before the edge, advance the model at the
  // edge, return at the following negedge. Transferred data is scoreboarded
  // here; a stalled head must stay valid with unchanged data.
  task automatic step();
    logic          xfer, hold;
    logic [DW-1:0] got, exp;
    int            old;
    xfer = ram_read_valid_o && ram_read_ready_i;
    hold = ram_read_valid_o && !ram_read_ready_i && !flush_i && !rst_i;
    got  = ram_read_data_o;
    old  = exp_q.size();
    @(posedge clk);
    if (rst_i) begin
      exp_q.delete();
      m_ovf = 1'b0; m_drops = 0; m_peak = 0; m_bufrdy = 1'b0;
    end else begin
      m_bufrdy = (old >= THRESH);
      if (flush_i) begin
        exp_q.delete();
        m_ovf = 1'b0; m_drops = 0; m_peak = 0;
      end else begin
        if (old > m_peak) m_peak = old;
        if (xfer) begin
          n_xfer++;
          n_vec++;
          if (old == 0) begin
            n_err++;
            $display("FAIL xfer_data: transfer of %06h while model empty", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_err++;
              $display("FAIL xfer_data: got %06h expected %06h", got, exp);
            end
          end
        end
        if (wr_valid_i) begin
          if (old < DEPTH) exp_q.push_back(wr_data_i);
          else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
          end
        end
      end
    end
    @(negedge clk);
    if (hold) begin
      n_vec++;
      if (ram_read_valid_o !== 1'b1 || ram_read_data_o !== got) begin
        n_err++;
        $display("FAIL hold_stable: valid %b data %06h, required 1 %06h",
                 ram_read_valid_o, ram_read_data_o, got);
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; wr_valid_i = 1'b0; flush_i = 1'b0; ram_read_ready_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; wr_valid_i = 1'b1; flush_i = 1'b1; ram_read_ready_i = 1'b1;
    wr_data_i = 24'h5A5A5A;
    step(); step();
    n_vec += 7;
    if (fill_o !== '0) begin n_err++; $display("FAIL rst_fill: got %0d need 0", fill_o); end
    if (ram_read_valid_o !== 1'b0) begin
      n_err++; $display("FAIL rst_valid: got %b need 0", ram_read_valid_o);
    end
    if (ram_read_data_o !== '0) begin
      n_err++; $display("FAIL rst_data: got %06h need 0", ram_read_data_o);
    end
    if (ram_buffer_ready_o !== 1'b0) begin
      n_err++; $display("FAIL rst_bufrdy: got %b need 0", ram_buffer_ready_o);
    end
    if (overflow_o !== 1'b0) begin
      n_err++; $display("FAIL rst_ovf: got %b need 0", overflow_o);
    end
    if (drop_count_o !== '0) begin
      n_err++; $display("FAIL rst_drops: got %0d need 0", drop_count_o);
    end
    if (peak_fill_o !== '0) begin
      n_err++; $display("FAIL rst_peak: got %0d need 0", peak_fill_o);
    end
    rst_i = 1'b0; wr_valid_i = 1'b0; flush_i = 1'b0; ram_read_ready_i = 1'b0;
  endtask

  task automatic test_single_write();
    ram_read_ready_i = 1'b1;
    repeat (6) step();
    wr_valid_i = 1'b1; wr_data_i = 24'h7FFFFF;
    step();
    wr_valid_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_vec += 2;
      if (fill_o !== FW'(1)) begin
        n_err++; $display("FAIL single_fill: cycle N+%0d got %0d need 1", k, fill_o);
      end
      if (ram_read_valid_o !== (k == 3)) begin
        n_err++;
        $display("FAIL single_valid: cycle N+%0d got %b need %b", k, ram_read_valid_o, k == 3);
      end
      if (k < 3) step();
    end
    n_vec++;
    if (ram_read_data_o !== 24'h7FFFFF) begin
      n_err++; $display("FAIL single_data: got %06h need 7fffff", ram_read_data_o);
    end
    step();
    n_vec++;
    if (fill_o !== '0) begin n_err++; $display("FAIL single_drain: got %0d need 0", fill_o); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vals [3];
    vals[0] = 24'h000001; vals[1] = 24'hFFFFFF; vals[2] = 24'h800000;
    ram_read_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_data_i = vals[i];
      step();
    end
    wr_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if (ram_read_valid_o !== 1'b1 || ram_read_data_o !== 24'h000001) begin
        n_err++;
        $display("FAIL bp_hold: valid %b data %06h, need 1 000001",
                 ram_read_valid_o, ram_read_data_o);
      end
      step();
    end
    ram_read_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (ram_read_valid_o !== (k % 2 == 0)) begin
        n_err++;
        $display("FAIL bp_rate: slot %0d valid %b need %b", k, ram_read_valid_o, k % 2 == 0);
      end
      step();
    end
    n_vec++;
    if (fill_o !== '0) begin n_err++; $display("FAIL bp_drain: got %0d need 0", fill_o); end
  endtask

  task automatic test_overflow();
    int start;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_valid_i = 1'b1; wr_data_i = DW'($urandom());
      step();
    end
    wr_valid_i = 1'b0;
    n_vec += 3;
    if (fill_o !== FW'(8)) begin n_err++; $display("FAIL ovf_fill: got %0d need 8", fill_o); end
    if (overflow_o !== 1'b1) begin
      n_err++; $display("FAIL ovf_flag: got %b need 1", overflow_o);
    end
    if (drop_count_o !== 16'd2) begin
      n_err++; $display("FAIL ovf_drops: got %0d need 2", drop_count_o);
    end
    start = n_xfer;
    ram_read_ready_i = 1'b1;
    for (int i = 0; i < 40 && fill_o != '0; i++) step();
    ram_read_ready_i = 1'b0;
    n_vec += 2;
    if (fill_o !== '0) begin n_err++; $display("FAIL ovf_drain: got %0d need 0", fill_o); end
    if (n_xfer - start != 8) begin
      n_err++; $display("FAIL ovf_count: got %0d transfers need 8", n_xfer - start);
    end
  endtask

  task automatic test_stream();
    do_reset();
    ram_read_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 3; j++) begin
        wr_valid_i = (j == 0); wr_data_i = DW'($urandom());
        step();
        n_vec += 2;
        if (fill_o > FW'(2) || fill_o !== FW'(exp_q.size())) begin
          n_err++;
          $display("FAIL stream_fill: got %0d need %0d (<=2)", fill_o, exp_q.size());
        end
        if (ram_buffer_ready_o !== 1'b0) begin
          n_err++; $display("FAIL stream_bufrdy: got %b need 0", ram_buffer_ready_o);
        end
      end
    end
    wr_valid_i = 1'b0;
    for (int i = 0; i < 10 && fill_o != '0; i++) step();
    n_vec++;
    if (fill_o !== '0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL stream_drain: got %0d need 0", fill_o);
    end
  endtask

  task automatic test_threshold();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid_i = 1'b1; wr_data_i = DW'($urandom());
      step();
      n_vec += 2;
      if (fill_o !== FW'(i + 1)) begin
        n_err++; $display("FAIL thr_fill: got %0d need %0d", fill_o, i + 1);
      end
      if (ram_buffer_ready_o !== 1'b0) begin
        n_err++; $display("FAIL thr_early: got %b need 0 at fill %0d", ram_buffer_ready_o, i + 1);
      end
    end
    wr_valid_i = 1'b0;
    step();
    n_vec++;
    if (ram_buffer_ready_o !== 1'b1) begin
      n_err++; $display("FAIL thr_rise: got %b need 1", ram_buffer_ready_o);
    end
    ram_read_ready_i = 1'b1;
    step();
    ram_read_ready_i = 1'b0;
    n_vec += 2;
    if (fill_o !== FW'(3)) begin n_err++; $display("FAIL thr_read: got %0d need 3", fill_o); end
    if (ram_buffer_ready_o !== 1'b1) begin
      n_err++; $display("FAIL thr_lag: got %b need 1", ram_buffer_ready_o);
    end
    step();
    n_vec++;
    if (ram_buffer_ready_o !== 1'b0) begin
      n_err++; $display("FAIL thr_fall: got %b need 0", ram_buffer_ready_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wr_valid_i = 1'b1; wr_data_i = DW'($urandom());
      step();
    end
    wr_valid_i = 1'b0;
    step();
    ram_read_ready_i = 1'b1;
    step();
    ram_read_ready_i = 1'b0;
    // Output stage now holds a read in flight.
    flush_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 24'hABCDEF;
    step();
    flush_i = 1'b0; wr_valid_i = 1'b0;
    n_vec += 4;
    if (ram_read_valid_o !== 1'b0) begin
      n_err++; $display("FAIL flush_valid: got %b need 0", ram_read_valid_o);
    end
    if (fill_o !== '0) begin n_err++; $display("FAIL flush_fill: got %0d need 0", fill_o); end
    if (overflow_o !== 1'b0) begin
      n_err++; $display("FAIL flush_ovf: got %b need 0", overflow_o);
    end
    if (drop_count_o !== '0) begin
      n_err++; $display("FAIL flush_drops: got %0d need 0", drop_count_o);
    end
    ram_read_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_vec++;
      if (ram_read_valid_o !== 1'b0) begin
        n_err++; $display("FAIL flush_ghost: got valid %b need 0", ram_read_valid_o);
      end
    end
    ram_read_ready_i = 1'b0;
    wr_valid_i = 1'b1; wr_data_i = 24'h123456;
    step();
    wr_valid_i = 1'b0;
    step(); step();
    n_vec++;
    if (ram_read_valid_o !== 1'b1 || ram_read_data_o !== 24'h123456) begin
      n_err++;
      $display("FAIL flush_next: valid %b data %06h need 1 123456",
               ram_read_valid_o, ram_read_data_o);
    end
    ram_read_ready_i = 1'b1;
    step();
    ram_read_ready_i = 1'b0;
  endtask

  task automatic test_random();
    int wr_pct, rd_pct;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        wr_pct = $urandom_range(20, 90);
        rd_pct = $urandom_range(5, 90);
      end
      wr_valid_i       = ($urandom_range(0, 99) < wr_pct);
      wr_data_i        = DW'($urandom());
      ram_read_ready_i = ($urandom_range(0, 99) < rd_pct);
      flush_i          = ($urandom_range(0, 199) == 0);
      step();
      n_vec += 5;
      if (fill_o !== FW'(exp_q.size())) begin
        n_err++; $display("FAIL rnd_fill: got %0d need %0d", fill_o, exp_q.size());
      end
      if (overflow_o !== m_ovf) begin
        n_err++; $display("FAIL rnd_ovf: got %b need %b", overflow_o, m_ovf);
      end
      if (drop_count_o !== 16'(m_drops)) begin
        n_err++; $display("FAIL rnd_drops: got %0d need %0d", drop_count_o, m_drops);
      end
      if (ram_buffer_ready_o !== m_bufrdy) begin
        n_err++; $display("FAIL rnd_bufrdy: got %b need %b", ram_buffer_ready_o, m_bufrdy);
      end
      if (peak_fill_o !== FW'(exp_peak())) begin
        n_err++; $display("FAIL rnd_peak: got %0d need %0d", peak_fill_o, exp_peak());
      end
    end
    wr_valid_i = 1'b0; flush_i = 1'b0; ram_read_ready_i = 1'b1;
    for (int i = 0; i < 4 * DEPTH + 10 && exp_q.size() != 0; i++) step();
    step(); step();
    n_vec++;
    if (fill_o !== '0 || exp_q.size() != 0 || ram_read_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_drain: fill %0d model %0d valid %b, need 0 0 0",
               fill_o, exp_q.size(), ram_read_valid_o);
    end
    ram_read_ready_i = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_backpressure();
    test_overflow();
    test_stream();
    test_threshold();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
